// File: rtl/seq_det_pkg.sv
// Shared state encoding and default widths for the sequence-detector frame controller.
package seq_det_pkg;

   localparam int unsigned DefDataW = 16;
   localparam int unsigned DefPatW  = 5;
   localparam int unsigned DefCntW  = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } state_e;

endpackage

// File: rtl/seq_det_core.sv
// Programmable Mealy serial pattern detector (PAT_W >= 2).
// SEQ_DET_OVERLAP_EN selects overlapping detection; default is non-overlapping.
module seq_det_core
   import seq_det_pkg::*;
#(
   parameter int unsigned PAT_W = DefPatW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic             in_bit,
   input  logic [PAT_W-1:0] pattern,
   output logic             det
);

   localparam int unsigned HistW = PAT_W - 1;
   localparam int unsigned VldW  = $clog2(PAT_W);
`ifdef SEQ_DET_OVERLAP_EN
   localparam bit Overlap = 1'b1;
`else
   localparam bit Overlap = 1'b0;
`endif

   logic [HistW-1:0] hist_q, hist_d;
   logic [VldW-1:0]  vld_q, vld_d;
   logic             full;

   // vld_q counts history bits received since the last clear, saturating at HistW
   assign full = (vld_q == VldW'(HistW));
   assign det  = en && full && ({hist_q, in_bit} == pattern);

   always_comb begin
      hist_d = hist_q;
      vld_d  = vld_q;
      if (clear) begin
         hist_d = '0;
         vld_d  = '0;
      end else if (en) begin
         if (det && !Overlap) begin
            hist_d = '0;
            vld_d  = '0;
         end else begin
            hist_d = HistW'({hist_q, in_bit});
            vld_d  = full ? vld_q : vld_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hist_q <= '0;
         vld_q  <= '0;
      end else begin
         hist_q <= hist_d;
         vld_q  <= vld_d;
      end
   end

endmodule

// File: rtl/seq_det_ctrl.sv
// Frame controller: captures a word and pattern, serializes the word MSB-first into
// seq_det_core and tallies matches. Overlap mode is set by SEQ_DET_OVERLAP_EN in the core.
module seq_det_ctrl
   import seq_det_pkg::*;
#(
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned PAT_W  = DefPatW,
   parameter int unsigned CNT_W  = DefCntW
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [DATA_W-1:0]         data_in,
   input  logic [PAT_W-1:0]          pattern,
   output logic                      ready,
   output logic                      busy,
   output logic                      ser_bit,
   output logic                      det_pulse,
   output logic                      done,
   output logic [CNT_W-1:0]          det_count,
   output logic                      found,
   output logic [$clog2(DATA_W)-1:0] first_pos
);

   localparam int unsigned IdxW = $clog2(DATA_W);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_W - 1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [PAT_W-1:0]    pat_q, pat_d;
   logic [IdxW-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                found_q, found_d;
   logic [IdxW-1:0]     pos_q, pos_d;
   logic                accept;
   logic                in_shift;

   assign in_shift = (state_q == StShift);

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      pat_d   = pat_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      found_d = found_q;
      pos_d   = pos_q;
      accept  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               accept  = 1'b1;
               data_d  = data_in;
               pat_d   = pattern;
               idx_d   = '0;
               cnt_d   = '0;
               found_d = 1'b0;
               pos_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            // data_q MSB is always the bit on the wire
            data_d = data_q << 1;
            idx_d  = idx_q + 1'b1;
            if (det_pulse) begin
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               if (!found_q) begin
                  found_d = 1'b1;
                  pos_d   = idx_q;
               end
            end
            if (idx_q == LastIdx) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
         data_q  <= '0;
         pat_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         found_q <= 1'b0;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         pat_q   <= pat_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         found_q <= found_d;
         pos_q   <= pos_d;
      end
   end

   assign ready     = (state_q == StIdle);
   assign busy      = in_shift;
   assign done      = (state_q == StDone);
   assign ser_bit   = in_shift & data_q[DATA_W-1];
   assign det_count = cnt_q;
   assign found     = found_q;
   assign first_pos = pos_q;

   seq_det_core #(
      .PAT_W (PAT_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .clear   (accept),
      .en      (in_shift),
      .in_bit  (ser_bit),
      .pattern (pat_q),
      .det     (det_pulse)
   );

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl against a window-matching reference model.
module tb_seq_det_ctrl;

   localparam int DW   = 16;
   localparam int PW   = 5;
   localparam int CW   = 4;
   localparam int PosW = 4;
`ifdef SEQ_DET_OVERLAP_EN
   localparam bit Ovl = 1'b1;
`else
   localparam bit Ovl = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            start = 1'b0;
   logic [DW-1:0]   data_in = '0;
   logic [PW-1:0]   pattern = '0;
   logic            ready, busy, ser_bit, det_pulse, done, found;
   logic [CW-1:0]   det_count;
   logic [PosW-1:0] first_pos;

   // second instance: tiny counter and 2-bit pattern to reach saturation in either mode
   logic            s_start = 1'b0;
   logic [DW-1:0]   s_data = '0;
   logic [1:0]      s_pat = '0;
   logic            s_ready, s_busy, s_ser, s_det, s_done, s_found;
   logic [1:0]      s_count;
   logic [PosW-1:0] s_pos;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_det_ctrl #(.DATA_W(DW), .PAT_W(PW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .pattern(pattern),
      .ready(ready), .busy(busy), .ser_bit(ser_bit), .det_pulse(det_pulse), .done(done),
      .det_count(det_count), .found(found), .first_pos(first_pos)
   );

   seq_det_ctrl #(.DATA_W(DW), .PAT_W(2), .CNT_W(2)) sat_dut (
      .clk(clk), .rst(rst), .start(s_start), .data_in(s_data), .pattern(s_pat),
      .ready(s_ready), .busy(s_busy), .ser_bit(s_ser), .det_pulse(s_det), .done(s_done),
      .det_count(s_count), .found(s_found), .first_pos(s_pos)
   );

   // Stream bit k is d[15-k]; a match at k needs pw bits received since the last restart
   function automatic void model(input logic [15:0] d, input int pw, input int pat,
                                 input int cmax, output logic [15:0] mask, output int cnt,
                                 output logic fnd, output int fpos);
      int st;
      int w;
      st = 0; mask = '0; cnt = 0; fnd = 1'b0; fpos = 0;
      for (int k = 0; k < 16; k++) begin
         if (k - st >= pw - 1) begin
            w = 0;
            for (int j = k - pw + 1; j <= k; j++) w = (w << 1) | int'(d[15-j]);
            if (w == pat) begin
               mask[k] = 1'b1;
               if (cnt < cmax) cnt++;
               if (!fnd) begin
                  fnd  = 1'b1;
                  fpos = k;
               end
               if (!Ovl) st = k + 1;
            end
         end
      end
   endfunction

   // Entered and left at a negedge in IDLE; hold keeps start high for back-to-back frames
   task automatic run_frame(input logic [15:0] d, input logic [4:0] p, input bit hold,
                            input int poke_k, input string name);
      logic [15:0] mask;
      int cnt, fpos, rc, rp;
      logic fnd, rf;
      logic [4:0] got5, want5;
      logic [8:0] got9, want9;
      model(d, PW, int'(p), (1 << CW) - 1, mask, cnt, fnd, fpos);
      data_in = d; pattern = p; start = 1'b1;
      n_cmp++;
      if (ready !== 1'b1) begin
         n_err++; $display("FAIL %s ready-before-accept got=%b want=1", name, ready);
      end
      @(negedge clk);
      if (!hold) start = 1'b0;
      data_in = DW'($urandom); pattern = PW'($urandom);
      rc = 0; rf = 1'b0; rp = 0;
      for (int k = 0; k < 16; k++) begin
         if (k == poke_k) start = 1'b1;
         else if (!hold) start = 1'b0;
         got5  = {busy, ready, done, ser_bit, det_pulse};
         want5 = {1'b1, 1'b0, 1'b0, d[15-k], mask[k]};
         n_cmp++;
         if (got5 !== want5) begin
            n_err++;
            $display("FAIL %s shift k=%0d busy/ready/done/ser/det got=%b want=%b",
                     name, k, got5, want5);
         end
         got9  = {det_count, found, first_pos};
         want9 = {CW'(rc), rf, PosW'(rp)};
         n_cmp++;
         if (got9 !== want9) begin
            n_err++;
            $display("FAIL %s running k=%0d count/found/pos got=%h want=%h",
                     name, k, got9, want9);
         end
         if (mask[k]) begin
            if (rc < (1 << CW) - 1) rc++;
            if (!rf) begin
               rf = 1'b1;
               rp = k;
            end
         end
         @(negedge clk);
      end
      if (!hold) start = 1'b0;
      got5  = {busy, ready, done, ser_bit, det_pulse};
      want5 = 5'b00100;
      n_cmp++;
      if (got5 !== want5) begin
         n_err++; $display("FAIL %s done-cycle flags got=%b want=%b", name, got5, want5);
      end
      want9 = {CW'(cnt), fnd, PosW'(fpos)};
      got9  = {det_count, found, first_pos};
      n_cmp++;
      if (got9 !== want9) begin
         n_err++; $display("FAIL %s result count/found/pos got=%h want=%h", name, got9, want9);
      end
      @(negedge clk);
      got5  = {busy, ready, done, ser_bit, det_pulse};
      want5 = 5'b01000;
      got9  = {det_count, found, first_pos};
      n_cmp++;
      if (got5 !== want5 || got9 !== want9) begin
         n_err++;
         $display("FAIL %s after-done flags=%b results=%h want flags=%b results=%h",
                  name, got5, got9, want5, want9);
      end
   endtask

   task automatic test_reset();
      logic [8:0] got;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      got = {ready, busy, done, ser_bit, det_pulse, found, s_ready, s_done, s_det};
      n_cmp++;
      if (got !== 9'b100000100) begin
         n_err++; $display("FAIL reset flags got=%b want=100000100", got);
      end
      n_cmp++;
      if ({det_count, first_pos, s_count} !== 10'd0) begin
         n_err++; $display("FAIL reset values count=%0d pos=%0d got nonzero", det_count, first_pos);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      run_frame(16'hB580, 5'b10110, 1'b0, -1, "basic");
   endtask

   task automatic test_overlap_contrast();
      run_frame(16'hAA00, 5'b10101, 1'b0, -1, "overlap");
   endtask

   task automatic test_no_match();
      run_frame(16'h7BDE, 5'b11111, 1'b0, -1, "nomatch");
   endtask

   task automatic test_saturation();
      logic [15:0] mask;
      int cnt, fpos, rc;
      logic fnd;
      model(16'h0000, 2, 0, 3, mask, cnt, fnd, fpos);
      s_data = '0; s_pat = 2'b00; s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0; s_data = 16'hFFFF; s_pat = 2'b11;
      rc = 0;
      for (int k = 0; k < 16; k++) begin
         n_cmp++;
         if ({s_busy, s_ser, s_det, s_count} !== {1'b1, 1'b0, mask[k], 2'(rc)}) begin
            n_err++;
            $display("FAIL sat k=%0d busy/ser/det/count got=%b%b%b%0d want=10%b%0d",
                     k, s_busy, s_ser, s_det, s_count, mask[k], rc);
         end
         if (mask[k] && rc < 3) rc++;
         @(negedge clk);
      end
      n_cmp++;
      if ({s_done, s_count, s_found, s_pos} !== {1'b1, 2'(cnt), fnd, PosW'(fpos)}) begin
         n_err++;
         $display("FAIL sat result done=%b count=%0d found=%b pos=%0d want 1 %0d %b %0d",
                  s_done, s_count, s_found, s_pos, cnt, fnd, fpos);
      end
      @(negedge clk);
   endtask

   task automatic test_ignore_start();
      run_frame(16'($urandom), 5'($urandom), 1'b0, 3, "ignore");
      for (int i = 0; i < 20; i++) begin
         n_cmp++;
         if ({done, ready} !== 2'b01) begin
            n_err++; $display("FAIL ignore extra-done i=%0d done=%b ready=%b want 0 1", i, done, ready);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      run_frame(16'hB580, 5'b10110, 1'b1, -1, "b2b0");
      run_frame(16'h0F0F, 5'b01111, 1'b1, -1, "b2b1");
      run_frame(16'($urandom), 5'($urandom), 1'b0, -1, "b2b2");
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] got;
      data_in = 16'hB580; pattern = 5'b10110; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      got = {ready, busy, done, ser_bit, det_pulse, found, |det_count, |first_pos};
      n_cmp++;
      if (got !== 8'b10000000) begin
         n_err++; $display("FAIL midreset state got=%b want=10000000", got);
      end
      for (int i = 0; i < 20; i++) begin
         n_cmp++;
         if (done !== 1'b0) begin
            n_err++; $display("FAIL midreset spurious-done i=%0d got=%b want=0", i, done);
         end
         @(negedge clk);
      end
      run_frame(16'hAA00, 5'b10101, 1'b0, -1, "postreset");
   endtask

   task automatic test_random();
      logic [15:0] d;
      logic [4:0] p;
      for (int i = 0; i < 20; i++) begin
         d = 16'($urandom);
         // half the time lift the pattern from the word so matches actually occur
         p = ($urandom_range(0, 1) == 1) ? d[15 - $urandom_range(0, 11) -: 5] : 5'($urandom);
         run_frame(d, p, 1'($urandom_range(0, 1)) && (i != 19), -1, "random");
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_overlap_contrast();
      test_no_match();
      test_saturation();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
